// File: rtl/synth_pkg.sv
// Shared synth types: sequencer states, key index type and default key count.
// Imported by the voice_sequencer slice.
package synth_pkg;

   localparam int NUM_KEYS_DEF = 128;

   typedef logic [6:0] key_t;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      SCAN,
      FETCH,
      ACC,
      DONE
   } seq_state_t;

endpackage

// File: rtl/voice_sequencer_if.sv
// Note event handshake between the key source and the voice sequencer.
// Master drives the event, slave answers with EVT_READY.
import synth_pkg::*;

interface voice_sequencer_if;

   logic EVT_VALID;
   logic EVT_READY;
   key_t EVT_KEY;
   logic EVT_ON;

   modport master (
      output EVT_VALID,
      output EVT_KEY,
      output EVT_ON,
      input  EVT_READY
   );

   modport slave (
      input  EVT_VALID,
      input  EVT_KEY,
      input  EVT_ON,
      output EVT_READY
   );

endinterface

// File: rtl/voice_counter.sv
// Running popcount of the active key flags.
// inc/dec are one-cycle strobes from the flag set/clear logic.
module voice_counter (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       inc,
   input  logic       dec,
   output logic [7:0] count
);

   // set and clear never collide; a simultaneous pair leaves the count
   always_ff @(posedge CLK) begin
      if (RESET)
         count <= '0;
      else if (inc && !dec)
         count <= count + 8'd1;
      else if (dec && !inc)
         count <= count - 8'd1;
   end

endmodule

// File: rtl/voice_sequencer.sv
// Per-sample key scanner driving the wavetable datapath controls.
// Optional voice cap enabled by defining VOICE_LIMIT_EN.
import synth_pkg::*;

module voice_sequencer #(
   parameter int NUM_KEYS   = NUM_KEYS_DEF,
   parameter int MAX_VOICES = 16
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                SAMPLE_TICK,
   voice_sequencer_if.slave    evt,
   input  logic                NOTE_END,
   output key_t                KEY,
   output logic                LD_PHASE,
   output logic                LD_COUNT,
   output logic                LD_TONE,
   output logic                TONE_MUX,
   output logic                COUNTER_MUX,
   output logic                PHASE_MUX,
   output logic                NOTE_ON,
   output logic                SAMPLE_DONE,
   output logic                BUSY,
   output logic                OVERRUN,
   output logic [7:0]          ACTIVE_COUNT,
   output logic [7:0]          DROP_COUNT
);

`ifdef VOICE_LIMIT_EN
   localparam bit LIMIT_EN = 1'b1;
`else
   localparam bit LIMIT_EN = 1'b0;
`endif

   localparam logic [7:0] LAST = 8'(NUM_KEYS);

   seq_state_t state_q, state_d;
   logic [7:0] idx_q, idx_d, nidx;
   logic [NUM_KEYS-1:0] active_q, held_q, start_q;
   key_t cur;
   logic accept, drop, set_on, inc, clr_act, adv;

   assign cur = idx_q[6:0];
   assign BUSY = (state_q != IDLE);
   assign evt.EVT_READY = (state_q == IDLE);
   assign accept = evt.EVT_VALID && (state_q == IDLE);
   assign drop = accept && evt.EVT_ON && LIMIT_EN
               && !active_q[evt.EVT_KEY]
               && (ACTIVE_COUNT == 8'(MAX_VOICES));
   assign set_on = accept && evt.EVT_ON && !drop;
   assign inc = set_on && !active_q[evt.EVT_KEY];
   assign clr_act = (state_q == ACC) && NOTE_END && !held_q[cur];

   // state and scan index registers
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // next state with look-ahead so an active key costs only FETCH+ACC
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      adv         = 1'b0;
      KEY         = '0;
      LD_PHASE    = 1'b0;
      LD_COUNT    = 1'b0;
      LD_TONE     = 1'b0;
      TONE_MUX    = 1'b0;
      COUNTER_MUX = 1'b0;
      PHASE_MUX   = 1'b0;
      NOTE_ON     = 1'b0;
      SAMPLE_DONE = 1'b0;
      nidx = (state_q == CLEAR) ? 8'd0 : idx_q + 8'd1;
      unique case (state_q)
         IDLE:
            if (SAMPLE_TICK) state_d = CLEAR;
         CLEAR: begin
            LD_TONE = 1'b1;
            adv     = 1'b1;
         end
         SCAN:
            if (active_q[cur]) state_d = FETCH;
            else adv = 1'b1;
         FETCH: begin
            KEY         = cur;
            NOTE_ON     = held_q[cur];
            PHASE_MUX   = ~start_q[cur];
            COUNTER_MUX = ~start_q[cur];
            TONE_MUX    = 1'b1;
            state_d     = ACC;
         end
         ACC: begin
            KEY         = cur;
            NOTE_ON     = held_q[cur];
            PHASE_MUX   = ~start_q[cur];
            COUNTER_MUX = ~start_q[cur];
            TONE_MUX    = 1'b1;
            LD_PHASE    = 1'b1;
            LD_COUNT    = 1'b1;
            LD_TONE     = 1'b1;
            adv         = 1'b1;
         end
         DONE: begin
            SAMPLE_DONE = 1'b1;
            state_d     = IDLE;
         end
         default:
            state_d = IDLE;
      endcase
      if (adv) begin
         idx_d = nidx;
         if (nidx == LAST)
            state_d = DONE;
         else if (active_q[nidx[6:0]])
            state_d = FETCH;
         else
            state_d = SCAN;
      end
   end

   // key flags: events write in IDLE, ACC retires start and ended notes
   always_ff @(posedge CLK) begin
      if (RESET) begin
         active_q <= '0;
         held_q   <= '0;
         start_q  <= '0;
      end else begin
         if (set_on) begin
            active_q[evt.EVT_KEY] <= 1'b1;
            held_q[evt.EVT_KEY]   <= 1'b1;
            start_q[evt.EVT_KEY]  <= 1'b1;
         end else if (accept && !evt.EVT_ON && active_q[evt.EVT_KEY]) begin
            held_q[evt.EVT_KEY] <= 1'b0;
         end
         if (state_q == ACC) begin
            start_q[cur] <= 1'b0;
            if (clr_act) active_q[cur] <= 1'b0;
         end
      end
   end

   // sticky overrun and saturating drop counter
   always_ff @(posedge CLK) begin
      if (RESET) begin
         OVERRUN    <= 1'b0;
         DROP_COUNT <= '0;
      end else begin
         if (SAMPLE_TICK && state_q != IDLE) OVERRUN <= 1'b1;
         if (drop && DROP_COUNT != 8'hFF) DROP_COUNT <= DROP_COUNT + 8'd1;
      end
   end

   voice_counter u_cnt (
      .CLK   (CLK),
      .RESET (RESET),
      .inc   (inc),
      .dec   (clr_act),
      .count (ACTIVE_COUNT)
   );

endmodule

// File: tb/tb_voice_sequencer.sv
// Scoreboard bench for voice_sequencer: key-array reference model feeds
// expected loads and scan-end times, a negedge monitor pops and compares.
import synth_pkg::*;

module tb_voice_sequencer;

`ifdef VOICE_LIMIT_EN
   localparam bit LIM = 1'b1;
`else
   localparam bit LIM = 1'b0;
`endif
   localparam int MAXV = 16;
   localparam int NK = 128;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tick = 1'b0;
   logic note_end = 1'b0;
   key_t key;
   logic ld_phase, ld_count, ld_tone, tone_mux, counter_mux, phase_mux;
   logic note_on, sample_done, busy, overrun;
   logic [7:0] active_count, drop_count;

   voice_sequencer_if ev ();

   voice_sequencer #(
      .NUM_KEYS   (NK),
      .MAX_VOICES (MAXV)
   ) dut (
      .CLK          (clk),
      .RESET        (rst),
      .SAMPLE_TICK  (tick),
      .evt          (ev),
      .NOTE_END     (note_end),
      .KEY          (key),
      .LD_PHASE     (ld_phase),
      .LD_COUNT     (ld_count),
      .LD_TONE      (ld_tone),
      .TONE_MUX     (tone_mux),
      .COUNTER_MUX  (counter_mux),
      .PHASE_MUX    (phase_mux),
      .NOTE_ON      (note_on),
      .SAMPLE_DONE  (sample_done),
      .BUSY         (busy),
      .OVERRUN      (overrun),
      .ACTIVE_COUNT (active_count),
      .DROP_COUNT   (drop_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;

   function automatic void chk(string name, int got, int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  name, got, exp, cyc);
      end
   endfunction

   typedef struct {
      int key;
      bit non;
      bit mux;
   } rec_t;

   typedef struct {
      int at;
      int n;
   } done_t;

   rec_t  exp_q[$];
   done_t done_q[$];
   int    scan_loads = 0;

   bit m_act[NK];
   bit m_held[NK];
   bit m_start[NK];
   int m_drop;
   bit m_ovr;

   function automatic int m_count();
      int n = 0;
      for (int k = 0; k < NK; k++) n += int'(m_act[k]);
      return n;
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < NK; k++) begin
         m_act[k] = 0;
         m_held[k] = 0;
         m_start[k] = 0;
      end
      m_drop = 0;
      m_ovr = 0;
      exp_q.delete();
      done_q.delete();
      scan_loads = 0;
   endfunction

   function automatic void model_event(int k, bit on);
      if (on) begin
         if (LIM && !m_act[k] && m_count() == MAXV) begin
            if (m_drop < 255) m_drop++;
         end else begin
            m_act[k] = 1;
            m_held[k] = 1;
            m_start[k] = 1;
         end
      end else if (m_act[k]) begin
         m_held[k] = 0;
      end
   endfunction

   // one sample: every active key is loaded once, in key order
   function automatic void model_tick(int t, bit ne);
      int n = 0;
      rec_t r;
      done_t d;
      for (int k = 0; k < NK; k++) begin
         if (m_act[k]) begin
            r.key = k;
            r.non = m_held[k];
            r.mux = !m_start[k];
            exp_q.push_back(r);
            n++;
            m_start[k] = 0;
            if (ne && !m_held[k]) m_act[k] = 0;
         end
      end
      d.at = t + NK + n + 2;
      d.n = n;
      done_q.push_back(d);
   endfunction

   always @(negedge clk) begin
      rec_t r;
      done_t d;
      if (ld_phase) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_load", int'(key), -1);
         end else begin
            r = exp_q.pop_front();
            chk("acc_key", int'(key), r.key);
            chk("acc_note_on", int'(note_on), int'(r.non));
            chk("acc_phase_mux", int'(phase_mux), int'(r.mux));
            chk("acc_counter_mux", int'(counter_mux), int'(r.mux));
            chk("acc_strobes", int'({ld_count, ld_tone, tone_mux}), 7);
         end
         scan_loads++;
      end else if (ld_tone) begin
         chk("clear_tone_mux", int'(tone_mux), 0);
         chk("clear_key", int'(key), 0);
      end
      if (sample_done) begin
         if (done_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            d = done_q.pop_front();
            chk("done_cycle", cyc, d.at);
            chk("scan_loads", scan_loads, d.n);
         end
         scan_loads = 0;
      end
   end

   task automatic wait_idle();
      int i = 0;
      @(negedge clk);
      while (busy && i < 400) begin
         @(negedge clk);
         i++;
      end
      chk("idle_wait", int'(busy), 0);
   endtask

   task automatic do_event(int k, bit on);
      wait_idle();
      chk("evt_ready", int'(ev.EVT_READY), 1);
      ev.EVT_VALID = 1'b1;
      ev.EVT_KEY = 7'(k);
      ev.EVT_ON = on;
      model_event(k, on);
      @(negedge clk);
      ev.EVT_VALID = 1'b0;
      chk("active_count", int'(active_count), m_count());
      chk("drop_count", int'(drop_count), m_drop);
   endtask

   task automatic do_tick(bit ne);
      wait_idle();
      note_end = ne;
      tick = 1'b1;
      model_tick(cyc, ne);
      @(negedge clk);
      tick = 1'b0;
   endtask

   task automatic do_tick_ev(int k, bit on, bit ne);
      wait_idle();
      note_end = ne;
      tick = 1'b1;
      ev.EVT_VALID = 1'b1;
      ev.EVT_KEY = 7'(k);
      ev.EVT_ON = on;
      model_event(k, on);
      model_tick(cyc, ne);
      @(negedge clk);
      tick = 1'b0;
      ev.EVT_VALID = 1'b0;
   endtask

   task automatic finish_scan();
      wait_idle();
      chk("post_active_count", int'(active_count), m_count());
      chk("post_overrun", int'(overrun), int'(m_ovr));
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int i;
      ev.EVT_VALID = 1'b0;
      ev.EVT_KEY = '0;
      ev.EVT_ON = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ready", int'(ev.EVT_READY), 1);
      chk("rst_outs", int'({ld_phase, ld_count, ld_tone, tone_mux,
                            counter_mux, phase_mux, note_on,
                            sample_done, overrun}), 0);
      chk("rst_key", int'(key), 0);
      chk("rst_counts", int'({active_count, drop_count}), 0);
      rst = 1'b0;

      do_event(60, 1);
      do_tick(0);
      finish_scan();
      do_tick(0);
      finish_scan();
      do_event(60, 0);
      do_tick(1);
      finish_scan();
      chk("released_count", int'(active_count), 0);
      do_tick(0);
      finish_scan();

      do_event(5, 1);
      do_event(90, 1);
      do_tick(0);
      repeat (20) @(negedge clk);
      chk("busy_mid_scan", int'(busy), 1);
      tick = 1'b1;
      m_ovr = 1;
      @(negedge clk);
      tick = 1'b0;
      finish_scan();
      chk("overrun_sticky", int'(overrun), 1);

      apply_reset();
      for (int k = 0; k < 17; k++) do_event(100 + k, 1);
      chk("cap_count", int'(active_count), LIM ? MAXV : 17);
      chk("cap_drops", int'(drop_count), LIM ? 1 : 0);
      do_event(100, 1);
      chk("retrig_drops", int'(drop_count), LIM ? 1 : 0);
      do_tick(1);
      finish_scan();
      for (int k = 0; k < 8; k++) do_event(100 + k, 0);
      do_tick(1);
      finish_scan();

      apply_reset();
      do_event(10, 1);
      do_event(40, 1);
      do_event(70, 1);
      do_tick(0);
      i = 0;
      @(negedge clk);
      while (key != 7'd40 && i < 300) begin
         @(negedge clk);
         i++;
      end
      chk("reach_key40", int'(key), 40);
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_ready", int'(ev.EVT_READY), 1);
      chk("mid_rst_count", int'(active_count), 0);
      chk("mid_rst_loads", int'({ld_phase, ld_tone, key}), 0);
      rst = 1'b0;
      do_tick(1);
      finish_scan();

      apply_reset();
      repeat (25) begin
         int nev = $urandom_range(0, 5);
         for (int e = 0; e < nev; e++)
            do_event($urandom_range(0, 31), $urandom_range(0, 2) != 0);
         if ($urandom_range(0, 3) == 0)
            do_tick_ev($urandom_range(0, 127), 1'b1, 1'($urandom_range(0, 1)));
         else
            do_tick(1'($urandom_range(0, 1)));
         finish_scan();
      end

      repeat (3) @(negedge clk);
      chk("exp_q_drained", exp_q.size(), 0);
      chk("done_q_drained", done_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/voice_sequencer.md
VOICE_SEQUENCER -- requirements
Module: voice_sequencer

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 128, number of key slots scanned per sample.
REQ-002 SHALL have parameter MAX_VOICES, default 16, simultaneous-voice cap; used only with VOICE_LIMIT_EN.
REQ-003 SHALL have ports: CLK input 1 system clock; RESET input 1 synchronous active-high reset.
REQ-004 SHALL have ports: SAMPLE_TICK input 1, one-cycle strobe at the audio sample rate.
REQ-005 SHALL have ports: EVT_VALID input 1; EVT_READY output 1; EVT_KEY input 7; EVT_ON input 1 (1 = note-on, 0 = note-off).
REQ-006 SHALL have ports: NOTE_END input 1, the end-of-release flag from the datapath.
REQ-007 SHALL have ports: KEY output 7; LD_PHASE, LD_COUNT, LD_TONE, TONE_MUX, COUNTER_MUX, PHASE_MUX, NOTE_ON outputs 1 each (datapath controls).
REQ-008 SHALL have ports: SAMPLE_DONE output 1 (accumulated tone valid); BUSY output 1; OVERRUN output 1 (sticky); ACTIVE_COUNT output 8; DROP_COUNT output 8.

Function
REQ-009 SHALL keep per key three flags: active, held, start.
REQ-010 SHALL implement states IDLE, CLEAR, SCAN, FETCH, ACC, DONE; BUSY = state != IDLE.
REQ-011 SHALL drive EVT_READY = 1 only in IDLE; an event is accepted when EVT_VALID & EVT_READY.
REQ-012 SHALL, on accepted note-on: set active, held and start for EVT_KEY (retrigger if already active).
REQ-013 SHALL, on accepted note-off: clear held only; an inactive key is left unchanged.
REQ-014 SHALL, when SAMPLE_TICK occurs in IDLE, go to CLEAR the next cycle; an event accepted in the same cycle is visible to that scan.
REQ-015 SHALL, when SAMPLE_TICK occurs outside IDLE, ignore the tick and set OVERRUN until reset.
REQ-016 SHALL, in CLEAR (1 cycle): LD_TONE=1, TONE_MUX=0, all other loads 0; then SCAN with index 0.
REQ-017 SHALL, in SCAN with an inactive index: assert no load and advance the index, 1 cycle per key.
REQ-018 SHALL, in SCAN with an active index: go to FETCH without advancing.
REQ-019 SHALL, in FETCH (1 cycle, wavetable read latency): KEY=index, NOTE_ON=held, PHASE_MUX=COUNTER_MUX=~start, TONE_MUX=1, no loads.
REQ-020 SHALL, in ACC (1 cycle): drive the FETCH values plus LD_PHASE=LD_COUNT=LD_TONE=1, clear start, sample NOTE_END, and advance the index.
REQ-021 SHALL, when NOTE_END=1 in ACC and held=0: clear active for that key.
REQ-022 SHALL ignore NOTE_END when held=1.
REQ-023 SHALL, after index NUM_KEYS-1: enter DONE, pulse SAMPLE_DONE 1 cycle, return to IDLE.
REQ-024 SHALL, outside FETCH and ACC, drive KEY=0 and all muxes 0, so no datapath register changes.
REQ-025 SHALL keep ACTIVE_COUNT equal to the popcount of the active flags, updated the cycle after each change.
REQ-026 SHALL give a scan latency of NUM_KEYS + active + 2 cycles from tick to SAMPLE_DONE; for example, 146 cycles with 16 active voices and 128 keys.

Reset
REQ-027 SHALL, on RESET (including mid-scan), go to IDLE next cycle and clear all active, held and start flags.
REQ-028 SHALL reset all outputs to 0: OVERRUN, DROP_COUNT, ACTIVE_COUNT, SAMPLE_DONE, loads, muxes and KEY; EVT_READY becomes 1 in IDLE.

Configuration
REQ-029 SHALL, with VOICE_LIMIT_EN defined: drop a note-on for an inactive key when ACTIVE_COUNT == MAX_VOICES, and increment DROP_COUNT (saturating at 255).
REQ-030 SHALL, with VOICE_LIMIT_EN defined: always accept a retrigger of an already-active key.
REQ-031 SHALL, without VOICE_LIMIT_EN: accept every note-on and hold DROP_COUNT at 0.

Structure
REQ-032 SHALL take from shared package synth_pkg: state enum seq_state_t, NUM_KEYS_DEF=128, key_t (7-bit).
REQ-033 SHALL place ACTIVE_COUNT maintenance in sub-module voice_counter (increment/decrement on flag set/clear).

Verification
REQ-034 SHALL cover: reset, then note-on key 60 and a tick -> CLEAR, 60 SCAN cycles, then FETCH/ACC on KEY=60 with PHASE_MUX=COUNTER_MUX=0 and LD strobes in ACC, SAMPLE_DONE at cycle 131.
REQ-035 SHALL cover: a second tick with key 60 held -> PHASE_MUX=COUNTER_MUX=1, NOTE_ON=1.
REQ-036 SHALL cover: note-off key 60, then tick with NOTE_END=1 in ACC -> active cleared, ACTIVE_COUNT 1->0; the next tick issues no loads for key 60.
REQ-037 SHALL cover: tick during a scan -> OVERRUN=1; the scan completes normally.
REQ-038 SHALL cover, with VOICE_LIMIT_EN and MAX_VOICES=16: 17 distinct note-ons -> ACTIVE_COUNT=16, DROP_COUNT=1; retrigger of an active key is accepted.
REQ-039 SHALL cover: RESET asserted at key 40 of a scan -> IDLE next cycle, all flags 0, EVT_READY=1.
